// File: rtl/apb_master_bridge.sv
// APB initiator: turns one valid/ready request into a single APB transfer and
// returns read data plus the number of wait states on a valid/ready response.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WAIT_CNT_WIDTH = 8
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [WAIT_CNT_WIDTH-1:0] rsp_wait_cycles,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_ONE = {{(WAIT_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
  logic                      pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [WAIT_CNT_WIDTH-1:0] rsp_wait_q, rsp_wait_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_wait_q  <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_wait_q  <= rsp_wait_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_wait_d  = rsp_wait_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      IDLE: begin
        // Address/data are captured only here, while psel is low.
        if (req_valid) begin
          paddr_d    = req_addr;
          pwrite_d   = req_write;
          pwdata_d   = req_wdata;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          wait_cnt_d = '0;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_wait_d  = wait_cnt_q;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign req_ready       = (state_q == IDLE);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_wait_cycles = rsp_wait_q;
  assign paddr           = paddr_q;
  assign psel            = psel_q;
  assign penable         = penable_q;
  assign pwrite          = pwrite_q;
  assign pwdata          = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus random
// transfers against a transaction-level expectation model and an APB monitor.
module tb_apb_master_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WW = 8;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b1;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [WW-1:0] rsp_wait_cycles;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;

  int checks = 0;
  int errors = 0;
  int n_acc, n_rsp;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CNT_WIDTH(WW)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_wait_cycles(rsp_wait_cycles),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completed APB transfers, in order.
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_wdata[$];
  always @(posedge pclk)
    if (preset_n && psel && penable && pready) begin
      log_addr.push_back(paddr);
      log_wdata.push_back(pwdata);
    end

  // APB protocol monitor.
  logic          prev_psel = 1'b0, prev_pen = 1'b0, prev_pwrite = 1'b0;
  logic [AW-1:0] prev_paddr = '0;
  logic [DW-1:0] prev_pwdata = '0;
  always @(negedge pclk) begin
    if (preset_n) begin
      if (prev_psel && psel) begin
        check("apb_paddr_stable", paddr, prev_paddr);
        check("apb_pwdata_pwrite_stable", {pwrite, pwdata}, {prev_pwrite, prev_pwdata});
      end
      if (psel && !penable) check("setup_after_idle", prev_psel, 0);
      if (prev_psel && !prev_pen) check("setup_one_cycle", {psel, penable}, 2'b11);
      check("penable_implies_psel", penable & ~psel, 0);
    end
    prev_psel   <= psel;
    prev_pen    <= penable;
    prev_pwrite <= pwrite;
    prev_paddr  <= paddr;
    prev_pwdata <= pwdata;
  end

  // One complete transfer, starting at a negedge with the bridge idle.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int nwait, input logic [DW-1:0] rd, input int hold, input string tag);
    int edges, psel_n, pen_n, waits_given, busy_ready;
    logic stable;
    logic [DW-1:0] exp_rd;
    logic [WW-1:0] exp_wait;
    edges = 0; psel_n = 0; pen_n = 0; waits_given = 0; busy_ready = 0;
    exp_rd   = wr ? '0 : rd;
    exp_wait = (nwait > (2**WW - 1)) ? '1 : WW'(nwait);

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'($urandom); pready = 1'($urandom); prdata = $urandom;
    check({tag, "_req_ready_idle"}, req_ready, 1);
    @(posedge pclk); edges = 1;
    @(negedge pclk);
    check({tag, "_setup_phase"}, {psel, penable}, 2'b10);
    check({tag, "_paddr"}, paddr, addr);
    check({tag, "_pwrite_pwdata"}, {pwrite, pwdata}, {wr, wdata});

    while (!rsp_valid && edges < nwait + 10) begin
      req_valid = 1'($urandom); req_write = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom; rsp_ready = 1'($urandom);
      if (req_ready) busy_ready++;
      if (psel) psel_n++;
      if (penable) pen_n++;
      if (penable) begin
        pready = (waits_given == nwait);
        prdata = pready ? rd : $urandom;
        if (!pready) waits_given++;
      end else begin
        pready = 1'($urandom);
        prdata = $urandom;
      end
      @(posedge pclk); edges++;
      @(negedge pclk);
    end

    check({tag, "_rsp_valid"}, rsp_valid, 1);
    if (!rsp_valid) return;
    check({tag, "_latency"}, edges, nwait + 3);
    check({tag, "_psel_cycles"}, psel_n, nwait + 2);
    check({tag, "_penable_cycles"}, pen_n, nwait + 1);
    check({tag, "_no_accept_busy"}, busy_ready, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_rsp_wait"}, rsp_wait_cycles, exp_wait);
    check({tag, "_resp_psel_pen_ready"}, {psel, penable, req_ready}, 3'b000);

    req_valid = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0; pready = 1'($urandom); prdata = $urandom;
      @(posedge pclk); @(negedge pclk);
      if (!(rsp_valid && rsp_rdata == exp_rd && rsp_wait_cycles == exp_wait && !psel && !req_ready))
        stable = 1'b0;
    end
    if (hold > 0) check({tag, "_backpressure_stable"}, stable, 1);

    rsp_ready = 1'b1;
    @(posedge pclk); @(negedge pclk);
    check({tag, "_after_hs_valid_ready"}, {rsp_valid, req_ready}, 2'b01);
    check({tag, "_after_hs_fields"}, {rsp_wait_cycles, rsp_rdata}, {exp_wait, exp_rd});
    rsp_ready = 1'($urandom);
    $display("xfer %s: wr=%0d addr=0x%0h waits=%0d rdata=0x%0h wait_cycles=%0d",
             tag, wr, addr, nwait, rsp_rdata, rsp_wait_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0;
    #1 preset_n = 1'b0;
    repeat (2) @(negedge pclk);
    check("reset_apb", {psel, penable, pwrite}, 3'b000);
    check("reset_paddr", paddr, 0);
    check("reset_pwdata", pwdata, 0);
    check("reset_rsp", {rsp_valid, rsp_wait_cycles}, 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_req_ready", req_ready, 1);
    preset_n = 1'b1;
    @(negedge pclk);

    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, "t1_write");
    do_xfer(1'b0, 32'h24, 32'h0, 3, 32'h12345678, 0, "t2_read");
    do_xfer(1'b0, 32'h40, 32'h0, 1, 32'hCAFE0001, 5, "t3_backpressure");
    do_xfer(1'b0, 32'h44, 32'h0, 300, 32'hA5A5A5A5, 0, "t4_saturate");

    // Reset in the middle of an ACCESS phase.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30; req_wdata = '0;
    pready = 1'b0; rsp_ready = 1'b0;
    @(posedge pclk); @(negedge pclk);
    req_valid = 1'b0;
    @(posedge pclk); @(negedge pclk);
    check("t5_in_access", {psel, penable}, 2'b11);
    #2 preset_n = 1'b0;
    #1;
    check("t5_async_clear", {psel, penable, rsp_valid}, 3'b000);
    check("t5_req_ready_in_reset", req_ready, 1);
    pready = 1'b1; prdata = 32'hBAD0BAD0;
    @(negedge pclk);
    preset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); @(negedge pclk);
      check("t5_no_rsp", {rsp_valid, psel}, 2'b00);
    end
    do_xfer(1'b0, 32'h8, 32'h0, 1, 32'h0BADF00D, 1, "t5_read_after");

    // Back-to-back writes with req_valid held high.
    pready = 1'b1; rsp_ready = 1'b1;
    log_addr.delete(); log_wdata.delete();
    n_acc = 0; n_rsp = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h1;
    for (int cyc = 0; cyc < 40 && n_rsp < 2; cyc++) begin
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        check("t6_rsp_fields", {rsp_wait_cycles, rsp_rdata}, 0);
      end
      if (req_valid && req_ready) n_acc++;
      @(posedge pclk); @(negedge pclk);
      if (n_acc == 1) begin
        req_addr = 32'h4; req_wdata = 32'h2;
      end else if (n_acc == 2) begin
        req_valid = 1'b0;
      end
    end
    check("t6_accepts", n_acc, 2);
    check("t6_responses", n_rsp, 2);
    check("t6_apb_count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("t6_first", {log_addr[0], log_wdata[0]}, {32'h0, 32'h1});
      check("t6_second", {log_addr[1], log_wdata[1]}, {32'h4, 32'h2});
    end
    $display("xfer t6_back_to_back: accepts=%0d responses=%0d", n_acc, n_rsp);

    for (int t = 0; t < 20; t++) begin
      do_xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)), $urandom,
              int'($urandom_range(0, 3)), $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator that converts a simple valid/ready request stream into single APB transfers.
- Returns read data and a wait-state count on a valid/ready response channel.
- Drives the master side of apb_interface; the matrix-multiplier control path uses it to access peripheral and configuration slaves.
- One transfer outstanding at a time. Output timing satisfies every apb_interface protocol assertion (idle/setup/access sequencing, address/data stability, psel held through the transfer).

Parameters:
- ADDR_WIDTH, 32, width of req_addr and paddr.
- DATA_WIDTH, 32, width of write/read data paths.
- WAIT_CNT_WIDTH, 8, width of the saturating wait-state counter.

Ports:
- pclk  in  1  clock.
- preset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  transfer address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_wait_cycles  out  WAIT_CNT_WIDTH  number of ACCESS cycles with pready=0, saturating.
- paddr  out  ADDR_WIDTH  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  APB slave ready.
- prdata  in  DATA_WIDTH  APB read data.

Behaviour:
- Single clock pclk; reset preset_n is asynchronous, active-low. Reset is applied immediately and released synchronously into IDLE.
- Reset values: psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_wait_cycles=0; state=IDLE.
- All APB outputs and response outputs are registered. req_ready is combinational: req_ready = (state==IDLE), so it reads 1 during reset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On req_valid, latch paddr<=req_addr, pwrite<=req_write, pwdata<=req_wdata.
  - Set psel<=1, penable<=0, clear the wait counter, go to SETUP.
  - Without req_valid, hold all outputs; paddr/pwrite/pwdata keep their last values.
- SETUP (psel=1, penable=0): unconditionally set penable<=1 and go to ACCESS. This lasts exactly one cycle.
- ACCESS (psel=1, penable=1):
  - pready=0: stay in ACCESS. The wait counter increments and saturates at 2^WAIT_CNT_WIDTH-1.
  - pready=1: psel<=0, penable<=0, rsp_valid<=1, rsp_wait_cycles<=counter, rsp_rdata<= (pwrite ? 0 : prdata). Go to RESP.
- RESP:
  - psel=0. Hold rsp_valid and the response fields stable until rsp_ready.
  - On the handshake, rsp_valid<=0 and go to IDLE. rsp_rdata and rsp_wait_cycles keep their values.
- No new request is accepted in SETUP, ACCESS or RESP.
- At least one psel=0 cycle always separates consecutive transfers (RESP plus IDLE). Minimum latency from accept to rsp_valid is 3 cycles.
- paddr, pwrite and pwdata change only on request acceptance, which happens while psel=0. They never change while psel=1.
- pready and prdata are ignored outside ACCESS.
- Reset mid-transfer (any state): all outputs go to their reset values asynchronously. The transfer is abandoned and no response is produced. The next request after release proceeds normally.
- rsp_ready asserted while rsp_valid=0 has no effect.

Test Plan:
1. Write with zero wait states:
   - Stimulus: req addr=0x10, wdata=0xDEADBEEF, write=1; rsp_ready=1; pready=1.
   - Response: psel high for 2 cycles, penable high in the 2nd only, pwdata=0xDEADBEEF throughout. rsp_valid 3 cycles after accept, rsp_rdata=0, rsp_wait_cycles=0.
2. Read with 3 wait states:
   - Stimulus: req addr=0x24, write=0; pready low for 3 ACCESS cycles, then high with prdata=0x12345678.
   - Response: penable high for 4 cycles, rsp_rdata=0x12345678, rsp_wait_cycles=3.
3. Response backpressure:
   - Stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid rises.
   - Response: rsp_valid and rsp_rdata stay stable, psel=0, req_ready=0. One cycle after rsp_ready=1, req_ready=1.
4. Wait-counter saturation:
   - Stimulus: WAIT_CNT_WIDTH=8, pready held low for 300 ACCESS cycles.
   - Response: rsp_wait_cycles=255; psel and penable remain 1 throughout the wait.
5. Reset mid-transfer:
   - Stimulus: assert preset_n=0 asynchronously during ACCESS.
   - Response: psel, penable and rsp_valid drop to 0 before the next pclk edge, with no response issued. A subsequent read of 0x8 completes normally.
6. Back-to-back requests:
   - Stimulus: req_valid held high with two writes (0x0/0x1, 0x4/0x2); pready=1, rsp_ready=1.
   - Response: two complete transfers in order, with psel=0 for at least 1 cycle between them. paddr/pwdata are never changed while psel=1, and all apb_interface assertions pass.
